// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the boot-time program loader.
//   - RAM_ADDR_W / RAM_DATA_W: geometry of the 256x16 block RAM shared with
//     the TinyMIPS core.
//   - ld_state_e: loader state encoding (3 bits), LD_IDLE .. LD_ERR.
package program_loader_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_HI    = 3'd1,
    LD_LO    = 3'd2,
    LD_WRITE = 3'd3,
    LD_CHK   = 3'd4,
    LD_RUN   = 3'd5,
    LD_ERR   = 3'd6
  } ld_state_e;

endpackage

// File: rtl/program_loader.sv
// program_loader
//   Receives a framed program over a byte stream (count byte, 16-bit words
//   high byte first, checksum byte), writes the words into the shared RAM
//   from address 0 while holding the core in reset, and on a good checksum
//   releases the core and hands it the RAM port through a transparent mux.
//
// Ports
//   clk         in   1       single clock, posedge
//   rst         in   1       synchronous active-high reset
//   byte_in     in   8       stream byte
//   byte_valid  in   1       byte_in valid this cycle
//   byte_ready  out  1       loader accepts byte_in (transfer = valid & ready)
//   cpu_wrEn    in   1       core write enable (used only in RUN)
//   cpu_addr    in   ADDR_W  core RAM address (used only in RUN)
//   cpu_data    in   DATA_W  core write data (used only in RUN)
//   ram_we      out  1       RAM write enable
//   ram_addr    out  ADDR_W  RAM address
//   ram_din     out  DATA_W  RAM write data
//   cpu_rst     out  1       core reset, high until load verified
//   done        out  1       load verified, core running
//   err         out  1       checksum mismatch, sticky until rst
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              cpu_wrEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  // One extra bit so a count byte of 0 can stand for a full 2**ADDR_W load.
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        hi_byte;
  logic [7:0]        lo_byte;
  logic [7:0]        sum;
  logic              xfer;
  logic              last_word;

  assign xfer      = byte_valid & byte_ready;
  // Compare against cnt-1 in the wider domain so the 256-word case ends at
  // addr 255 without the address counter ever wrapping.
  assign last_word = ({1'b0, addr} == (cnt - 1'b1));

  // Loader sequencing. cpu_rst/done/err are registered alongside the state
  // so cpu_rst drops in the very first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LD_IDLE;
      addr    <= '0;
      cnt     <= '0;
      sum     <= '0;
      hi_byte <= '0;
      lo_byte <= '0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (xfer) begin
            cnt   <= (byte_in == 8'd0) ? CNT_FULL : CNT_W'(byte_in);
            sum   <= byte_in;
            addr  <= '0;
            state <= LD_HI;
          end
        end
        LD_HI: begin
          if (xfer) begin
            hi_byte <= byte_in;
            sum     <= sum + byte_in;
            state   <= LD_LO;
          end
        end
        LD_LO: begin
          if (xfer) begin
            lo_byte <= byte_in;
            sum     <= sum + byte_in;
            state   <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          if (last_word) begin
            state <= LD_CHK;
          end else begin
            addr  <= addr + 1'b1;
            state <= LD_HI;
          end
        end
        LD_CHK: begin
          if (xfer) begin
            if (byte_in == sum) begin
              state   <= LD_RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= LD_ERR;
              err   <= 1'b1;
            end
          end
        end
        LD_RUN: state <= LD_RUN;
        LD_ERR: state <= LD_ERR;
        default: begin
          state   <= LD_IDLE;
          cpu_rst <= 1'b1;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Stream handshake: only the byte-consuming states accept, and never
  // while reset is held.
  always_comb begin
    byte_ready = 1'b0;
    if (!rst) begin
      byte_ready = (state == LD_IDLE) || (state == LD_HI) ||
                   (state == LD_LO)   || (state == LD_CHK);
    end
  end

  // RAM port mux: loader owns it in WRITE, the core owns it in RUN with no
  // added latency; otherwise writes are blocked.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr;
    ram_din  = {hi_byte, lo_byte};
    case (state)
      LD_WRITE: ram_we = 1'b1;
      LD_RUN: begin
        ram_we   = cpu_wrEn;
        ram_addr = cpu_addr;
        ram_din  = cpu_data;
      end
      default: ram_we = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader. Expected RAM writes are queued as the
//   stream is driven and checked as the loader issues them; a small RAM
//   model keeps what the loader wrote.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        cpu_wrEn = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_data = 16'h0000;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        cpu_rst;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [15:0] stimWords[$];
  logic [15:0] tbRam[256];
  int          compared = 0;
  int          mismatched = 0;
  int          writeCount = 0;

  program_loader dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .cpu_wrEn  (cpu_wrEn),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Loader-phase writes (done low) are popped against the queue; any write
  // with nothing queued is an error.
  always @(negedge clk) begin
    if (ram_we && !done) begin
      writeCount++;
      tbRam[ram_addr] = ram_din;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", {8'h00, ram_addr, ram_din}, 32'h0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", {24'h0, ram_addr}, {24'h0, e.addr});
        checkOutput("wr_data", {16'h0, ram_din}, {16'h0, e.data});
      end
    end
  end

  // Offer one byte until it is accepted; gaps randomly drop valid.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    bit sent = 1'b0;
    int waitCnt = 0;
    while (!sent && waitCnt < 200) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = b;
        if (byte_ready) sent = 1'b1;
      end
      waitCnt++;
    end
    checkOutput("byte_accept_timeout", {31'h0, sent}, 32'h1);
  endtask

  function automatic logic [7:0] calcSum(input logic [7:0] cnt);
    logic [7:0] s = cnt;
    foreach (stimWords[i]) s = s + stimWords[i][15:8] + stimWords[i][7:0];
    return s;
  endfunction

  // Drive a whole frame from stimWords, queueing each expected write.
  task automatic applyStimulus(input logic [7:0] cnt, input logic [7:0] chk,
                               input bit gaps);
    sendByte(cnt, gaps);
    foreach (stimWords[i]) begin
      expQ.push_back('{addr: 8'(i), data: stimWords[i]});
      sendByte(stimWords[i][15:8], gaps);
      sendByte(stimWords[i][7:0], gaps);
    end
    sendByte(chk, gaps);
    checkOutput("done_in_chk", {31'h0, done}, 32'h0);
    checkOutput("cpu_rst_in_chk", {31'h0, cpu_rst}, 32'h1);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b1;
    #1 checkOutput("ready_in_rst", {31'h0, byte_ready}, 32'h0);
    @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_ram_we", {31'h0, ram_we}, 32'h0);
    rst = 1'b0;
    #1 checkOutput("idle_ready", {31'h0, byte_ready}, 32'h1);
    expQ.delete();
    writeCount = 0;
  endtask

  // After the checksum: valid held high must be ignored.
  task automatic checkIgnored(input string tag);
    for (int k = 0; k < 3; k++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      #1 checkOutput({tag, "_ready"}, {31'h0, byte_ready}, 32'h0);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    // Core write enable held high during loads; it must never reach RAM.
    cpu_wrEn = 1'b1;
    cpu_addr = 8'hEE;
    cpu_data = 16'hDEAD;

    $display("[TB] test 1: basic load");
    doReset();
    stimWords = '{16'h7205, 16'h1234};
    applyStimulus(8'h02, 8'hBF, 1'b0);
    checkOutput("t1_done", {31'h0, done}, 32'h1);
    checkOutput("t1_cpu_rst", {31'h0, cpu_rst}, 32'h0);
    checkOutput("t1_err", {31'h0, err}, 32'h0);
    checkOutput("t1_writes", writeCount, 32'd2);
    checkOutput("t1_ram0", {16'h0, tbRam[0]}, 32'h7205);
    checkOutput("t1_ram1", {16'h0, tbRam[1]}, 32'h1234);
    checkIgnored("t1_run");

    $display("[TB] test 2: bad checksum");
    doReset();
    stimWords = '{16'hABCD};
    applyStimulus(8'h01, 8'h00, 1'b0);
    checkOutput("t2_err", {31'h0, err}, 32'h1);
    checkOutput("t2_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    checkOutput("t2_done", {31'h0, done}, 32'h0);
    checkOutput("t2_ram0", {16'h0, tbRam[0]}, 32'hABCD);
    checkOutput("t2_ram_we_err", {31'h0, ram_we}, 32'h0);
    checkIgnored("t2_err");
    checkOutput("t2_err_sticky", {31'h0, err}, 32'h1);

    $display("[TB] test 3: backpressure and gaps");
    doReset();
    tbRam[0] = 16'h0000;
    tbRam[1] = 16'h0000;
    stimWords = '{16'h7205, 16'h1234};
    applyStimulus(8'h02, calcSum(8'h02), 1'b1);
    checkOutput("t3_done", {31'h0, done}, 32'h1);
    checkOutput("t3_writes", writeCount, 32'd2);
    checkOutput("t3_ram0", {16'h0, tbRam[0]}, 32'h7205);
    checkOutput("t3_ram1", {16'h0, tbRam[1]}, 32'h1234);

    $display("[TB] test 4: full depth");
    doReset();
    stimWords.delete();
    for (int i = 0; i < 256; i++) stimWords.push_back({8'(i), ~8'(i)});
    applyStimulus(8'h00, calcSum(8'h00), 1'b0);
    checkOutput("t4_done", {31'h0, done}, 32'h1);
    checkOutput("t4_writes", writeCount, 32'd256);
    checkOutput("t4_ram0", {16'h0, tbRam[0]}, 32'h00FF);
    checkOutput("t4_ram255", {16'h0, tbRam[255]}, 32'hFF00);

    $display("[TB] test 5: reset mid-load");
    doReset();
    stimWords = '{16'h7205, 16'h1234};
    expQ.push_back('{addr: 8'h00, data: 16'h7205});
    sendByte(8'h02, 1'b0);
    sendByte(8'h72, 1'b0);
    sendByte(8'h05, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    #1 checkOutput("t5_ready_rst", {31'h0, byte_ready}, 32'h0);
    @(negedge clk);
    checkOutput("t5_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    checkOutput("t5_done", {31'h0, done}, 32'h0);
    checkOutput("t5_ram_we", {31'h0, ram_we}, 32'h0);
    checkOutput("t5_partial_write", expQ.size(), 32'h0);
    rst = 1'b0;
    #1 checkOutput("t5_idle_ready", {31'h0, byte_ready}, 32'h1);
    writeCount = 0;
    applyStimulus(8'h02, 8'hBF, 1'b0);
    checkOutput("t5_done_final", {31'h0, done}, 32'h1);
    checkOutput("t5_cpu_rst_final", {31'h0, cpu_rst}, 32'h0);
    checkOutput("t5_writes", writeCount, 32'd2);

    $display("[TB] test 6: pass-through");
    cpu_wrEn = 1'b1;
    cpu_addr = 8'h10;
    cpu_data = 16'h00FF;
    #1;
    checkOutput("t6_we", {31'h0, ram_we}, 32'h1);
    checkOutput("t6_addr", {24'h0, ram_addr}, 32'h10);
    checkOutput("t6_din", {16'h0, ram_din}, 32'h00FF);
    cpu_wrEn = 1'b0;
    cpu_addr = 8'h42;
    cpu_data = 16'hBEEF;
    #1;
    checkOutput("t6_we_low", {31'h0, ram_we}, 32'h0);
    checkOutput("t6_addr2", {24'h0, ram_addr}, 32'h42);
    checkOutput("t6_din2", {16'h0, ram_din}, 32'hBEEF);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
